pc_ctrl: RTL and testbench
==========================

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, legal range 1..7, meaning the number of bubble cycles inserted after a redirect.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port stall, input, 1 bit: hazard stall request from decode.
REQ-006 SHALL have port ex_valid, input, 1 bit: the instruction in EX is valid.
REQ-007 SHALL have port br_taken, input, 1 bit: the branch unit resolved a taken branch or jump.
REQ-008 SHALL have port new_pc, input, 32 bits: the branch unit target address.
REQ-009 SHALL have port pc, output, 32 bits: registered fetch address.
REQ-010 SHALL have port pc_valid, output, 1 bit: pc is a valid fetch request this cycle.
REQ-011 SHALL have port flush, output, 1 bit: squash the IF/ID and ID/EX pipeline registers.
REQ-012 SHALL have port misalign, output, 1 bit: registered one-cycle pulse flagging a misaligned redirect target.
REQ-013 SHALL have port misalign_pc, output, 32 bits: the raw new_pc captured on the last misaligned redirect.

Function
REQ-014 SHALL implement states BOOT, RUN and FLUSH, plus a 3-bit bubble counter cnt.
REQ-015 SHALL define redirect = ex_valid & br_taken & (state == RUN), evaluated combinationally.
REQ-016 SHALL drive flush = redirect | (state == FLUSH) combinationally, so the squash lands on the same edge that loads the target.
REQ-017 SHALL drive pc_valid = (state == RUN) & ~redirect.
REQ-018 BOOT SHALL hold pc and move to RUN after exactly one cycle.
REQ-019 In RUN with redirect, the block SHALL load pc <= {new_pc[31:2], 2'b00}, load cnt <= FLUSH_CYCLES and enter FLUSH.
REQ-020 Redirect SHALL take priority over stall when both are asserted in the same cycle.
REQ-021 In RUN with no redirect and stall=1, pc SHALL hold its value.
REQ-022 In RUN with no redirect and stall=0, pc SHALL update to pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-023 In FLUSH, pc SHALL hold and cnt SHALL decrement each cycle; at cnt==1 the next state SHALL be RUN.
REQ-024 In FLUSH, ex_valid and br_taken SHALL be ignored, and stall SHALL have no effect.
REQ-025 On a redirect with new_pc[1:0] != 0, misalign SHALL be 1 for exactly the next cycle and misalign_pc SHALL capture new_pc; otherwise misalign SHALL be 0 and misalign_pc SHALL hold.
REQ-026 Latency from redirect to the first valid fetch of the target SHALL be FLUSH_CYCLES+1 cycles, counting the redirect cycle.

Reset
REQ-027 While rst=1 at a clock edge: pc <= RESET_PC, state <= BOOT, cnt <= 0, misalign <= 0, misalign_pc <= 0, and performance counters (if present) <= 0.
REQ-028 Reset SHALL override any redirect, stall or FLUSH activity in the same cycle, including a reset asserted mid-FLUSH.
REQ-029 During reset and in BOOT, outputs SHALL read pc_valid=0 and flush=0.

Configuration
REQ-030 Macro BR_PERF_EN, when defined, SHALL add outputs br_count[31:0], incremented on every redirect, and flush_count[31:0], incremented on every cycle with flush=1.
REQ-031 Both BR_PERF_EN counters SHALL wrap modulo 2^32.
REQ-032 Without BR_PERF_EN, those ports and their registers SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Release rst with RESET_PC=0 and stall=0 -> pc_valid=0 for 1 cycle, then pc sequence 0, 4, 8, 12 with pc_valid=1.
REQ-034 Assert stall for 3 cycles at pc=8 -> pc holds 8 for 3 cycles, then 12.
REQ-035 Assert ex_valid=1, br_taken=1, new_pc=0x100 with stall=1, FLUSH_CYCLES=2 -> flush=1 for 3 cycles and pc_valid=0; pc=0x100 becomes valid on the 4th cycle, then 0x104.
REQ-036 Assert br_taken=1 during FLUSH with new_pc=0x200 -> ignored; pc stays 0x100.
REQ-037 Redirect with new_pc=0x102 -> pc=0x100, one-cycle misalign pulse, misalign_pc=0x102.
REQ-038 Assert rst mid-FLUSH -> next cycle pc=RESET_PC, flush=0; with BR_PERF_EN defined, br_count=0 and flush_count=0.

Source files
------------

// File: rtl/pc_ctrl.sv
// pc_ctrl - program counter and redirect/flush controller for an in-order pipeline.
//
// Purpose:
//   Produces the fetch address each cycle. After reset the block waits one
//   BOOT cycle, then fetches sequentially (pc+4) unless decode requests a stall.
//   A taken branch/jump resolved in EX redirects fetch to the word-aligned
//   target and inserts FLUSH_CYCLES bubble cycles. Misaligned targets are
//   reported with a one-cycle pulse and the raw target is captured.
//
// Parameters:
//   RESET_PC     - pc value loaded on reset
//   FLUSH_CYCLES - bubble cycles after a redirect (1..7)
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   stall        in   hazard stall request from decode
//   ex_valid     in   instruction in EX is valid
//   br_taken     in   branch unit resolved a taken branch/jump
//   new_pc[31:0] in   branch target
//   pc[31:0]     out  registered fetch address
//   pc_valid     out  pc is a valid fetch request this cycle
//   flush        out  squash IF/ID and ID/EX
//   misalign     out  one-cycle pulse: last redirect target was misaligned
//   misalign_pc  out  raw target of the last misaligned redirect
//
// Optional feature (macro BR_PERF_EN):
//   br_count[31:0]    out  redirects seen (wraps)
//   flush_count[31:0] out  cycles with flush=1 (wraps)

module pc_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        br_taken,
  input  logic [31:0] new_pc,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        flush,
  output logic        misalign,
  output logic [31:0] misalign_pc
`ifdef BR_PERF_EN
  ,
  output logic [31:0] br_count,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [31:0] pc_next;
  logic        redirect;

  // Next-state, next-pc and combinational outputs.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pc_next    = pc;
    redirect   = ex_valid & br_taken & (state_reg == S_RUN);
    // Outputs are forced low while reset is asserted so nothing downstream
    // sees a fetch or squash from a state that is about to be discarded.
    flush      = ~rst & (redirect | (state_reg == S_FLUSH));
    pc_valid   = ~rst & (state_reg == S_RUN) & ~redirect;

    case (state_reg)
      S_BOOT: begin
        state_next = S_RUN;
      end
      S_RUN: begin
        // Redirect wins over stall.
        if (redirect) begin
          pc_next    = {new_pc[31:2], 2'b00};
          cnt_next   = FLUSH_INIT;
          state_next = S_FLUSH;
        end else if (!stall) begin
          pc_next = pc + 32'd4;
        end
      end
      S_FLUSH: begin
        // Branch inputs and stall are ignored while bubbles drain.
        cnt_next = cnt_reg - 3'd1;
        if (cnt_reg <= 3'd1) begin
          state_next = S_RUN;
        end
      end
      default: begin
        state_next = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_BOOT;
      cnt_reg     <= 3'd0;
      pc          <= RESET_PC;
      misalign    <= 1'b0;
      misalign_pc <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pc        <= pc_next;
      misalign  <= redirect & (new_pc[1:0] != 2'b00);
      if (redirect && (new_pc[1:0] != 2'b00)) begin
        misalign_pc <= new_pc;
      end
    end
  end

`ifdef BR_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count    <= 32'd0;
      flush_count <= 32'd0;
    end else begin
      if (redirect) br_count <= br_count + 32'd1;
      if (flush)    flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl - self-checking bench for pc_ctrl.
// A behavioural reference tracks the fetch address and the cycle number at
// which fetching resumes after a redirect; every cycle the DUT outputs are
// compared against it, and directed steps add explicit expected constants.

module tb_pc_ctrl;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam int          FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst, stall, ex_valid, br_taken;
  logic [31:0] new_pc;
  logic [31:0] pc, misalign_pc;
  logic        pc_valid, flush, misalign;
`ifdef BR_PERF_EN
  logic [31:0] br_count, flush_count;
`endif

  pc_ctrl #(.RESET_PC(RESET_PC), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid),
    .br_taken(br_taken), .new_pc(new_pc), .pc(pc), .pc_valid(pc_valid),
    .flush(flush), .misalign(misalign), .misalign_pc(misalign_pc)
`ifdef BR_PERF_EN
    , .br_count(br_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [31:0] m_pc, m_mpc;
  bit          m_boot, m_mis;
  longint      cyc, m_resume;
  logic [31:0] m_br, m_fl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_mpc = 32'd0; m_boot = 1; m_mis = 0;
    m_resume = 0; m_br = 0; m_fl = 0;
  endtask

  // Check current outputs against the reference, advance it, and clock once.
  task automatic step(input string tag);
    bit running, redir, e_flush, e_valid;
    #1;
    running = !m_boot && (cyc >= m_resume);
    redir   = !rst && running && ex_valid && br_taken;
    e_flush = !rst && (redir || (!m_boot && cyc < m_resume));
    e_valid = !rst && running && !redir;
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".pc_valid"}, {31'd0, pc_valid}, {31'd0, e_valid});
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, e_flush});
    chk({tag, ".misalign"}, {31'd0, misalign}, {31'd0, m_mis});
    chk({tag, ".misalign_pc"}, misalign_pc, m_mpc);
`ifdef BR_PERF_EN
    chk({tag, ".br_count"}, br_count, m_br);
    chk({tag, ".flush_count"}, flush_count, m_fl);
`endif
    $display("step %s cyc=%0d rst=%b stall=%b ex=%b br=%b new_pc=%h pc=%h valid=%b flush=%b",
             tag, cyc, rst, stall, ex_valid, br_taken, new_pc, pc, pc_valid, flush);
    if (rst) begin
      model_reset();
    end else begin
      if (redir) m_br = m_br + 32'd1;
      if (e_flush) m_fl = m_fl + 32'd1;
      m_mis = redir && (new_pc[1:0] != 2'b00);
      if (m_mis) m_mpc = new_pc;
      if (m_boot) begin
        m_boot = 0;
      end else if (redir) begin
        m_pc     = new_pc & 32'hFFFF_FFFC;
        m_resume = cyc + FLUSH_CYCLES + 1;
      end else if (running && !stall) begin
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit r, input bit s, input bit ev, input bit bt, input logic [31:0] np);
    rst = r; stall = s; ex_valid = ev; br_taken = bt; new_pc = np;
  endtask

  initial begin
    cyc = 0;
    set_in(1, 0, 0, 0, 32'd0);
    model_reset();
    @(posedge clk); #1;
    step("reset0");
    step("reset1");

    // Release reset: one BOOT cycle, then 0,4,8
    set_in(0, 0, 0, 0, 32'd0);
    step("boot");
    step("run0");
    step("run4");
    chk("seq.pc8", pc, 32'd8);

    // Stall 3 cycles at pc=8
    stall = 1;
    step("stall0"); step("stall1"); step("stall2");
    chk("stall.hold", pc, 32'd8);
    stall = 0;
    step("unstall");
    chk("after_stall.pc", pc, 32'd12);

    // Redirect with stall also asserted: redirect wins
    set_in(0, 1, 1, 1, 32'h100);
    step("redir100");
    chk("redir.pc", pc, 32'h100);
    // Branch request during FLUSH with a different target must be ignored
    set_in(0, 0, 1, 1, 32'h200);
    step("flush_ign0");
    step("flush_ign1");
    chk("flush_ign.pc", pc, 32'h100);
    set_in(0, 0, 0, 0, 32'd0);
    step("target_valid");
    chk("target_next.pc", pc, 32'h104);
    step("run104");

    // Misaligned redirect
    set_in(0, 0, 1, 1, 32'h102);
    step("mis_redir");
    set_in(0, 0, 0, 0, 32'd0);
    chk("mis.pc", pc, 32'h100);
    chk("mis.pulse", {31'd0, misalign}, 32'd1);
    chk("mis.pc_cap", misalign_pc, 32'h102);
    step("mis_pulse");
    chk("mis.pulse_end", {31'd0, misalign}, 32'd0);
    step("mis_flush2");
    step("mis_run");

    // Wrap at top of address space
    set_in(0, 0, 1, 1, 32'hFFFF_FFF8);
    step("wrap_redir");
    set_in(0, 0, 0, 0, 32'd0);
    step("wrap_f0"); step("wrap_f1");
    step("wrap_pc_f8"); step("wrap_pc_fc");
    chk("wrap.pc0", pc, 32'd0);
    step("wrap_pc0");

    // Reset mid-FLUSH
    set_in(0, 0, 1, 1, 32'h300);
    step("pre_rst_redir");
    set_in(1, 0, 1, 1, 32'h400);
    step("rst_midflush");
    set_in(0, 0, 0, 0, 32'd0);
    chk("rst_mid.pc", pc, RESET_PC);
    chk("rst_mid.flush", {31'd0, flush}, 32'd0);
`ifdef BR_PERF_EN
    chk("rst_mid.br_count", br_count, 32'd0);
    chk("rst_mid.flush_count", flush_count, 32'd0);
`endif
    step("post_rst_boot");

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      logic [31:0] np;
      np = $urandom;
      if ($urandom_range(0, 7) == 0) np = 32'hFFFF_FFF0 | (np & 32'hF);
      set_in($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0,
             1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, np);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
